// File: rtl/npu_cube_pkg.sv
// -----------------------------------------------------------------------------
// npu_cube_pkg
// Shared definitions for the cube partial-sum accumulator:
//   - default widths and the legal NUM_IN range
//   - beat_tag_t: per-stage control tag travelling alongside the datapath
//   - CSA_LEVELS(n): number of 3:2 compressor levels needed to reduce n
//     operands to a sum/carry pair
//   - csa_ops_after(n, levels): operand count left after 'levels' levels
// -----------------------------------------------------------------------------
package npu_cube_pkg;

    localparam int unsigned NUM_IN_DEF = 8;
    localparam int unsigned NUM_IN_MIN = 3;
    localparam int unsigned NUM_IN_MAX = 32;
    localparam int unsigned DWIN_DEF   = 19;
    localparam int unsigned DWACC_DEF  = 32;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_tag_t;

    // Each level turns every group of three operands into two; leftovers pass.
    function automatic int unsigned csa_ops_after(input int unsigned n, input int unsigned levels);
        int unsigned cnt;
        cnt = n;
        for (int unsigned i = 0; i < levels; i++) begin
            if (cnt > 2) cnt = 2 * (cnt / 3) + (cnt % 3);
        end
        return cnt;
    endfunction

    function automatic int unsigned CSA_LEVELS(input int unsigned n);
        int unsigned cnt;
        int unsigned lv;
        cnt = n;
        lv  = 0;
        while (cnt > 2) begin
            cnt = 2 * (cnt / 3) + (cnt % 3);
            lv++;
        end
        return lv;
    endfunction

endpackage

// File: rtl/npu_cube_csa32.sv
// -----------------------------------------------------------------------------
// npu_cube_csa32
// Bitwise 3:2 carry-save compressor.
//   A, B, Cin : WIDTH-bit operands
//   Sum       : A ^ B ^ Cin
//   Carry     : majority(A, B, Cin) already shifted left by one, so that
//               Sum + Carry == A + B + Cin (mod 2^WIDTH)
// -----------------------------------------------------------------------------
module npu_cube_csa32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Cin,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Carry
);

    assign Sum = A ^ B ^ Cin;

    // The majority out of the top bit would land beyond WIDTH, so it is never formed.
    assign Carry = {(A[WIDTH-2:0] & B[WIDTH-2:0]) |
                    (A[WIDTH-2:0] & Cin[WIDTH-2:0]) |
                    (B[WIDTH-2:0] & Cin[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/npu_cube_csa_acc.sv
// -----------------------------------------------------------------------------
// npu_cube_csa_acc
// Sums NUM_IN partial sums per beat through a registered 3:2 CSA tree, a
// registered carry-propagate add, and a burst accumulator.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : beat handshake (in_ready is combinational)
//   in_data              : NUM_IN packed elements, element k = [k*DWIN +: DWIN]
//   in_first / in_last   : burst delimiters (first clears, last emits)
//   out_valid/out_ready  : result handshake
//   out_data             : accumulated burst sum
//   out_sat              : burst saturated (only with NPU_CUBE_ACC_SAT_EN)
// Optional feature: define NPU_CUBE_ACC_SAT_EN to clamp the accumulator to the
// DWACC range and report a sticky per-burst saturation flag; otherwise the
// accumulator wraps modulo 2^DWACC and out_sat is 0.
// Latency: CSA_LEVELS + 2 registers from acceptance to out_valid.
// -----------------------------------------------------------------------------
module npu_cube_csa_acc
    import npu_cube_pkg::*;
#(
    parameter int unsigned NUM_IN = NUM_IN_DEF,
    parameter int unsigned DWIN   = DWIN_DEF,
    parameter int unsigned DWACC  = DWACC_DEF,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*DWIN-1:0] in_data,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWACC-1:0]       out_data,
    output logic                   out_sat
);

    localparam int unsigned LVL    = CSA_LEVELS(NUM_IN);
    localparam int unsigned BEAT_W = DWIN + $clog2(NUM_IN);
    // Tree width is at least DWACC and always wide enough for an exact beat
    // sum, so a single oversized beat can still be detected by saturation.
    localparam int unsigned TW     = (DWACC > BEAT_W) ? DWACC : BEAT_W;

    logic            advance;
    logic            fresh;
    logic [TW-1:0]   ext_ops [NUM_IN];
    logic [TW-1:0]   lvl_d   [LVL][NUM_IN];
    logic [TW-1:0]   lvl_q   [LVL][NUM_IN];
    beat_tag_t       lvl_tag [LVL];
    logic [TW-1:0]   cpa_sum;
    beat_tag_t       cpa_tag;
    logic [DWACC-1:0] acc;
    logic [DWACC-1:0] acc_next;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
        logic [DWIN-1:0] elem;
        assign elem       = in_data[k*DWIN +: DWIN];
        assign ext_ops[k] = {{(TW-DWIN){SIGNED & elem[DWIN-1]}}, elem};
    end

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        localparam int unsigned N_IN  = csa_ops_after(NUM_IN, l);
        localparam int unsigned GRP   = N_IN / 3;
        localparam int unsigned N_OUT = 2 * GRP + (N_IN % 3);

        logic [TW-1:0] src [NUM_IN];

        if (l == 0) begin : g_src_in
            assign src = ext_ops;
        end else begin : g_src_reg
            assign src = lvl_q[l-1];
        end

        for (genvar g = 0; g < GRP; g++) begin : g_csa
            npu_cube_csa32 #(.WIDTH(TW)) u_csa (
                .A     (src[3*g]),
                .B     (src[3*g+1]),
                .Cin   (src[3*g+2]),
                .Sum   (lvl_d[l][2*g]),
                .Carry (lvl_d[l][2*g+1])
            );
        end

        // Leftover operand 3*GRP+j moves to slot 2*GRP+j; unused slots are zero.
        for (genvar r = 2*GRP; r < NUM_IN; r++) begin : g_pass
            if (r < N_OUT) begin : g_keep
                assign lvl_d[l][r] = src[r + GRP];
            end else begin : g_zero
                assign lvl_d[l][r] = '0;
            end
        end
    end

    // Control tags and the post-reset "treat next beat as first" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned l = 0; l < LVL; l++) lvl_tag[l] <= '0;
            cpa_tag <= '0;
            fresh   <= 1'b1;
        end else if (advance) begin
            lvl_tag[0] <= '{valid: in_valid, first: in_first | fresh, last: in_last};
            for (int unsigned l = 1; l < LVL; l++) lvl_tag[l] <= lvl_tag[l-1];
            cpa_tag <= lvl_tag[LVL-1];
            if (in_valid) fresh <= 1'b0;
        end
    end

    // Datapath registers carry no reset: the tags decide what is consumed.
    always_ff @(posedge clk) begin
        if (advance) begin
            lvl_q   <= lvl_d;
            cpa_sum <= lvl_q[LVL-1][0] + lvl_q[LVL-1][1];
        end
    end

`ifdef NPU_CUBE_ACC_SAT_EN
    localparam int unsigned AW = TW + 1;

    logic [AW-1:0] base_x;
    logic [AW-1:0] beat_x;
    logic [AW-1:0] acc_sum;
    logic          sat_hit;
    logic          sat_run;
    logic          sat_next;

    always_comb begin
        base_x   = cpa_tag.first ? '0 : {{(AW-DWACC){SIGNED & acc[DWACC-1]}}, acc};
        beat_x   = {SIGNED & cpa_sum[TW-1], cpa_sum};
        acc_sum  = base_x + beat_x;
        acc_next = acc_sum[DWACC-1:0];
        sat_hit  = 1'b0;
        if (SIGNED) begin
            // In range only when every bit above the DWACC sign bit matches it.
            if (acc_sum[AW-1:DWACC-1] != {(AW-DWACC+1){acc_sum[AW-1]}}) begin
                sat_hit  = 1'b1;
                acc_next = acc_sum[AW-1] ? {1'b1, {(DWACC-1){1'b0}}}
                                         : {1'b0, {(DWACC-1){1'b1}}};
            end
        end else if (acc_sum[AW-1:DWACC] != '0) begin
            sat_hit  = 1'b1;
            acc_next = '1;
        end
        sat_next = (cpa_tag.first ? 1'b0 : sat_run) | sat_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_run <= 1'b0;
            out_sat <= 1'b0;
        end else if (advance && cpa_tag.valid) begin
            sat_run <= sat_next;
            if (cpa_tag.last) out_sat <= sat_next;
        end
    end
`else
    always_comb begin
        acc_next = (cpa_tag.first ? '0 : acc) + cpa_sum[DWACC-1:0];
    end

    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            if (cpa_tag.valid) begin
                acc <= acc_next;
                if (cpa_tag.last) out_data <= acc_next;
            end
            out_valid <= cpa_tag.valid & cpa_tag.last;
        end
    end

endmodule

// File: tb/tb_npu_cube_csa_acc.sv
// -----------------------------------------------------------------------------
// tb_npu_cube_csa_acc
// Three DUT lanes run the same phase sequence concurrently:
//   lane 0: DWIN=19 DWACC=32 unsigned
//   lane 1: DWIN=19 DWACC=32 signed
//   lane 2: DWIN=18 DWACC=20 unsigned (one beat can exceed the accumulator)
// Each issued beat updates an arithmetic burst model; every burst end pushes
// the expected result, and a monitor pops it on each output handshake.
// -----------------------------------------------------------------------------
module tb_npu_cube_csa_acc;

    localparam int unsigned NI = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int lanes_done = 0;

    for (genvar L = 0; L < 3; L++) begin : g_lane
        localparam int unsigned DW  = (L == 2) ? 18 : 19;
        localparam int unsigned DA  = (L == 2) ? 20 : 32;
        localparam bit          SG  = (L == 1);
        // Rising edges from the accepting edge (counted as 1) to the edge that
        // raises out_valid: 4 CSA levels + CPA + accumulate.
        localparam int          LAT = 6;

        logic              rst_n;
        logic              in_valid;
        logic              in_ready;
        logic [NI*DW-1:0]  in_data;
        logic              in_first;
        logic              in_last;
        logic              out_valid;
        logic              out_ready;
        logic [DA-1:0]     out_data;
        logic              out_sat;

        int     bp_mode = 0;    // 0: always ready, 1: random, 2: held low
        longint exp_d[$];
        bit     exp_s[$];
        longint acc_m;
        bit     sat_m;
        bit     fresh_m;

        npu_cube_csa_acc #(
            .NUM_IN (NI),
            .DWIN   (DW),
            .DWACC  (DA),
            .SIGNED (SG)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_first  (in_first),
            .in_last   (in_last),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_sat   (out_sat)
        );

        task automatic chk(input string name, input longint act, input longint req);
            checks++;
            if (act != req) begin
                failures++;
                $display("FAIL lane%0d %s: got %0d expected %0d", L, name, act, req);
            end
        endtask

        // Burst model: exact integer sum, then clamp or wrap to DA bits.
        task automatic model_beat(input logic [NI*DW-1:0] d, input bit f, input bit l);
            longint s, t, v, lo, hi, mask;
            logic [DW-1:0] e;
            s = 0;
            for (int k = 0; k < NI; k++) begin
                e = d[k*DW +: DW];
                v = longint'(e);
                if (SG && e[DW-1]) v = v - (longint'(1) << DW);
                s = s + v;
            end
            mask = (longint'(1) << DA) - 1;
            lo   = SG ? -(longint'(1) << (DA-1)) : 0;
            hi   = SG ? (longint'(1) << (DA-1)) - 1 : mask;
            if (f || fresh_m) begin
                acc_m = 0;
                sat_m = 0;
            end
            fresh_m = 0;
            t = acc_m + s;
`ifdef NPU_CUBE_ACC_SAT_EN
            if (t > hi) begin t = hi; sat_m = 1; end
            if (t < lo) begin t = lo; sat_m = 1; end
`else
            t = t & mask;
            if (SG && t > hi) t = t - (longint'(1) << DA);
`endif
            acc_m = t;
            if (l) begin
                exp_d.push_back(t & mask);
                exp_s.push_back(sat_m);
            end
        endtask

        function automatic logic [NI*DW-1:0] fill(input longint val);
            logic [NI*DW-1:0] d;
            for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'(val);
            return d;
        endfunction

        function automatic logic [NI*DW-1:0] rand_data();
            logic [NI*DW-1:0] d;
            for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'($urandom);
            return d;
        endfunction

        task automatic issue(input logic [NI*DW-1:0] d, input bit f, input bit l);
            int tries;
            tries = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_first = f;
            in_last  = l;
            #1;
            while (!in_ready && tries < 500) begin
                @(negedge clk);
                #1;
                tries++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL lane%0d accept_timeout: got in_ready=0 expected 1", L);
            end else begin
                model_beat(d, f, l);
                @(posedge clk);
            end
            #1 in_valid = 1'b0;
        endtask

        task automatic drain();
            int n;
            n = 0;
            bp_mode = 0;
            while (exp_d.size() != 0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (exp_d.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL lane%0d drain_timeout: got %0d pending expected 0", L, exp_d.size());
            end
            @(negedge clk);
        endtask

        task automatic wait_out_valid(input string name);
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk(name, longint'(out_valid), 1);
        endtask

        // Back-pressure driver.
        initial begin
            out_ready = 1'b1;
            forever begin
                @(negedge clk);
                case (bp_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 3) != 0);
                    default: out_ready = 1'b0;
                endcase
            end
        end

        // Scoreboard monitor: out_valid/out_ready are stable from here to the edge.
        always begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lane%0d unexpected_output: got %0d expected none", L, out_data);
                end else begin
                    chk("out_data", longint'(out_data), exp_d.pop_front());
                    chk("out_sat", longint'(out_sat), longint'(exp_s.pop_front()));
                end
            end
        end

        initial begin
            logic [NI*DW-1:0] d;
            int n;
            rst_n    = 1'b0;
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
            acc_m    = 0;
            sat_m    = 0;
            fresh_m  = 1;

            repeat (3) @(negedge clk);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_data", longint'(out_data), 0);
            chk("rst_out_sat", longint'(out_sat), 0);
            rst_n = 1'b1;
            @(negedge clk);
            #1;
            chk("idle_in_ready", longint'(in_ready), 1);

            // One-beat burst of eight 1000s, with latency measured in edges.
            d = fill(1000);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_first = 1'b1;
            in_last  = 1'b1;
            #1;
            chk("lat_in_ready", longint'(in_ready), 1);
            model_beat(d, 1'b1, 1'b1);
            @(posedge clk);
            n = 1;
            #1 in_valid = 1'b0;
            while (!out_valid && n < 40) begin
                @(posedge clk);
                n++;
                #1;
            end
            chk("latency_edges", longint'(n), longint'(LAT));
            drain();

            // Two-beat burst {-1 x8} then {+3 x8}.
            issue(fill(-1), 1'b1, 1'b0);
            issue(fill(3), 1'b0, 1'b1);
            drain();

            // Three results queued behind a held-low out_ready.
            bp_mode = 2;
            repeat (3) issue(rand_data(), 1'b1, 1'b1);
            wait_out_valid("stall_out_valid");
            repeat (5) begin
                @(negedge clk);
                #1;
                chk("stall_in_ready", longint'(in_ready), 0);
                chk("stall_out_data", longint'(out_data), exp_d[0]);
                chk("stall_out_sat", longint'(out_sat), longint'(exp_s[0]));
            end
            drain();

            // 200-beat burst of eight (2^18-1) per beat.
            for (int i = 0; i < 200; i++) issue(fill(262143), i == 0, i == 199);
            drain();

            // Random flags, data, gaps and back-pressure.
            bp_mode = 1;
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                issue(rand_data(), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            end
            drain();

            // Reset with a result waiting and a burst still open.
            bp_mode = 2;
            issue(rand_data(), 1'b1, 1'b1);
            issue(rand_data(), 1'b1, 1'b0);
            wait_out_valid("pre_rst_out_valid");
            @(negedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("async_rst_out_valid", longint'(out_valid), 0);
            chk("async_rst_out_data", longint'(out_data), 0);
            chk("async_rst_out_sat", longint'(out_sat), 0);
            exp_d.delete();
            exp_s.delete();
            acc_m   = 0;
            sat_m   = 0;
            fresh_m = 1;
            @(negedge clk);
            rst_n   = 1'b1;
            bp_mode = 0;
            d = '0;
            for (int k = 0; k < 5; k++) d[k*DW +: DW] = DW'(1);
            issue(d, 1'b0, 1'b1);
            drain();

            lanes_done++;
        end
    end

    initial begin
        wait (lanes_done == 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected all lanes done");
        $fatal(1, "watchdog expired");
    end

endmodule
